// File: rtl/branch_target_buffer_if.sv
// branch_target_buffer_if: fetch lookup, EX training and ID-stage prediction signals of the BTB
interface branch_target_buffer_if;
  logic [31:0] PC_IF;
  logic        StallID;
  logic        FlushID;
  logic        BranchValid_EX;
  logic        BranchTaken_EX;
  logic [31:0] PC_EX;
  logic [31:0] BranchTarget_EX;
  logic        BranchPredictSel;
  logic [31:0] BranchPredictTarget;
  logic        PredictHit_ID;
  modport master (
    output PC_IF, StallID, FlushID, BranchValid_EX, BranchTaken_EX, PC_EX, BranchTarget_EX,
    input  BranchPredictSel, BranchPredictTarget, PredictHit_ID
  );
  modport slave (
    input  PC_IF, StallID, FlushID, BranchValid_EX, BranchTaken_EX, PC_EX, BranchTarget_EX,
    output BranchPredictSel, BranchPredictTarget, PredictHit_ID
  );
endinterface

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with 2-bit saturating counters, registering its
// prediction into the ID stage and trained by conditional branches resolved in EX.
module branch_target_buffer #(
  parameter int         INDEX_BITS = 4,
  parameter logic [1:0] CTR_INIT   = 2'b01
) (
  input logic                   clk,
  input logic                   rst_n,
  branch_target_buffer_if.slave bus
);
  localparam int TAG_BITS = 30 - INDEX_BITS;
  localparam int ENTRIES  = 1 << INDEX_BITS;
  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];
  logic [INDEX_BITS-1:0] if_idx, ex_idx;
  logic [TAG_BITS-1:0]   if_tag, ex_tag;
  logic        if_hit, if_taken, ex_hit, upd_en;
  logic [31:0] if_target, upd_target;
  logic [1:0]  ex_ctr, upd_ctr;
  logic        sel_q, sel_d, hit_q, hit_d;
  logic [31:0] tgt_q, tgt_d;
  logic        unused_pc_lsbs;
  assign unused_pc_lsbs = ^{bus.PC_IF[1:0], bus.PC_EX[1:0]};
  assign if_idx    = bus.PC_IF[INDEX_BITS+1:2];
  assign if_tag    = bus.PC_IF[31:INDEX_BITS+2];
  assign ex_idx    = bus.PC_EX[INDEX_BITS+1:2];
  assign ex_tag    = bus.PC_EX[31:INDEX_BITS+2];
  assign if_hit    = valid_q[if_idx] && tag_q[if_idx] == if_tag;
  assign if_taken  = if_hit && ctr_q[if_idx][1];
  assign if_target = if_taken ? target_q[if_idx] : bus.PC_IF + 32'd4;
  assign ex_hit    = valid_q[ex_idx] && tag_q[ex_idx] == ex_tag;
  assign ex_ctr    = ctr_q[ex_idx];
  // A not-taken miss never allocates; every other resolved branch writes its entry.
  assign upd_en    = bus.BranchValid_EX && (ex_hit || bus.BranchTaken_EX);
  always_comb begin
    upd_ctr    = !ex_hit ? 2'b10
               : bus.BranchTaken_EX ? (ex_ctr == 2'b11 ? ex_ctr : ex_ctr + 2'd1)
               : (ex_ctr == 2'b00 ? ex_ctr : ex_ctr - 2'd1);
    upd_target = bus.BranchTaken_EX ? bus.BranchTarget_EX : target_q[ex_idx];
    sel_d      = bus.FlushID ? 1'b0  : bus.StallID ? sel_q : if_taken;
    tgt_d      = bus.FlushID ? 32'd0 : bus.StallID ? tgt_q : if_target;
    hit_d      = bus.FlushID ? 1'b0  : bus.StallID ? hit_q : if_hit;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= 1'b0;
      tgt_q <= 32'd0;
      hit_q <= 1'b0;
    end else begin
      sel_q <= sel_d;
      tgt_q <= tgt_d;
      hit_q <= hit_d;
    end
  end
  // Lookup reads the pre-update table; new contents appear from the next cycle on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'd0;
        ctr_q[i]    <= CTR_INIT;
      end
    end else if (upd_en) begin
      valid_q[ex_idx]  <= 1'b1;
      tag_q[ex_idx]    <= ex_tag;
      target_q[ex_idx] <= upd_target;
      ctr_q[ex_idx]    <= upd_ctr;
    end
  end
  assign bus.BranchPredictSel    = sel_q;
  assign bus.BranchPredictTarget = tgt_q;
  assign bus.PredictHit_ID       = hit_q;
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: random and directed stimulus against a table model, scoreboard-checked
module tb_branch_target_buffer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  branch_target_buffer_if bus();
  branch_target_buffer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    bit          v;
    logic [31:0] tag;
    logic [31:0] tgt;
    int          ctr;
  } ent_t;
  typedef struct packed {
    logic        sel;
    logic [31:0] tgt;
    logic        hit;
  } out_t;
  ent_t tbl [16];
  out_t exp_id;
  out_t q [$];
  int   checks = 0;
  int   fails = 0;
  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) & 32'hF);
  endfunction
  function automatic out_t lookup(logic [31:0] pc);
    out_t r;
    int i = idx_of(pc);
    r.hit = tbl[i].v && tbl[i].tag == (pc >> 6);
    r.sel = r.hit && tbl[i].ctr >= 2;
    r.tgt = r.sel ? tbl[i].tgt : pc + 32'd4;
    return r;
  endfunction
  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      tbl[i].v = 0;
      tbl[i].ctr = 1;
    end
    exp_id = '0;
  endtask
  task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] tg);
    int i = idx_of(pc);
    bit hit = tbl[i].v && tbl[i].tag == (pc >> 6);
    if (hit && taken) begin
      tbl[i].ctr = tbl[i].ctr < 3 ? tbl[i].ctr + 1 : 3;
      tbl[i].tgt = tg;
    end else if (hit) begin
      tbl[i].ctr = tbl[i].ctr > 0 ? tbl[i].ctr - 1 : 0;
    end else if (taken) begin
      tbl[i].v = 1;
      tbl[i].tag = pc >> 6;
      tbl[i].tgt = tg;
      tbl[i].ctr = 2;
    end
  endtask
  task automatic cycle(input logic [31:0] pif, input logic st, input logic fl,
                       input logic bv, input logic bt, input logic [31:0] pex, input logic [31:0] tg);
    bus.PC_IF = pif;
    bus.StallID = st;
    bus.FlushID = fl;
    bus.BranchValid_EX = bv;
    bus.BranchTaken_EX = bt;
    bus.PC_EX = pex;
    bus.BranchTarget_EX = tg;
    exp_id = fl ? '0 : st ? exp_id : lookup(pif);
    q.push_back(exp_id);
    if (bv) train(pex, bt, tg);
    @(negedge clk);
  endtask
  task automatic look(input logic [31:0] pif);
    cycle(pif, 0, 0, 0, 0, 32'd0, 32'd0);
  endtask
  task automatic check_zero(input string name);
    checks++;
    if ({bus.BranchPredictSel, bus.BranchPredictTarget, bus.PredictHit_ID} != '0) begin
      fails++;
      $display("FAIL %s sel/target/hit got %b/%h/%b expected 0/00000000/0", name,
               bus.BranchPredictSel, bus.BranchPredictTarget, bus.PredictHit_ID);
    end
  endtask
  initial begin
    out_t e, got;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        got = {bus.BranchPredictSel, bus.BranchPredictTarget, bus.PredictHit_ID};
        checks++;
        if (got != e) begin
          fails++;
          $display("FAIL id_out @%0t sel/target/hit got %b/%h/%b expected %b/%h/%b", $time,
                   got.sel, got.tgt, got.hit, e.sel, e.tgt, e.hit);
        end
      end
    end
  end
  initial begin
    logic [31:0] pif, pex;
    bus.PC_IF = 0; bus.StallID = 0; bus.FlushID = 0; bus.BranchValid_EX = 0;
    bus.BranchTaken_EX = 0; bus.PC_EX = 0; bus.BranchTarget_EX = 0;
    model_clear();
    #1 check_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    look(32'h0040_0010);
    cycle(32'h0040_0010, 0, 0, 1, 1, 32'h0040_0010, 32'h0040_0100);
    look(32'h0040_0010);
    cycle(32'h0040_0000, 0, 0, 1, 0, 32'h0040_0010, 32'h0);
    cycle(32'h0040_0000, 0, 0, 1, 0, 32'h0040_0010, 32'h0);
    look(32'h0040_0010);
    cycle(32'h0040_0010, 0, 0, 1, 0, 32'h0040_0010, 32'h0);
    look(32'h0040_0010);
    cycle(32'h0040_0010, 0, 0, 1, 1, 32'h0040_0010, 32'h0040_0300);
    look(32'h0040_0010);
    cycle(32'h0040_0010, 0, 0, 1, 1, 32'h0040_0050, 32'h0040_0200);
    look(32'h0040_0010);
    look(32'h0040_0053);
    cycle(32'h0040_0050, 1, 0, 0, 0, 32'h0, 32'h0);
    cycle(32'h0040_0010, 1, 0, 0, 0, 32'h0, 32'h0);
    cycle(32'h1234_5678, 1, 0, 0, 0, 32'h0, 32'h0);
    cycle(32'h0040_0050, 1, 1, 0, 0, 32'h0, 32'h0);
    look(32'hFFFF_FFFC);
    look(32'h0040_0050);
    rst_n = 1'b0;
    bus.BranchValid_EX = 1; bus.BranchTaken_EX = 1;
    bus.PC_EX = 32'h0040_0090; bus.BranchTarget_EX = 32'h0000_1234;
    #1 check_zero("async_reset");
    model_clear();
    q.push_back('0);
    @(negedge clk);
    rst_n = 1'b1;
    look(32'h0040_0090);
    look(32'h0040_0050);
    look(32'h0040_0010);
    for (int n = 0; n < 400; n++) begin
      pif = 32'h0040_0000 | (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 2)
          | 32'($urandom_range(0, 3));
      pex = 32'h0040_0000 | (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 2)
          | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) pif = 32'hFFFF_FFFC;
      cycle(pif, $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pex, $urandom & 32'hFFFF_FFFC);
    end
    look(32'h0040_0000);
    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain queue size got %0d expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
